// File: rtl/ps2_pkg.sv
// PS/2 scan-code constants and quadrant-index types for the quadrant selector.
// Pure definitions; no logic, no latency.
package ps2_pkg;

   typedef logic [3:0] quad_idx_t;

   typedef struct packed {
      logic      hit;
      quad_idx_t idx;
   } sel_t;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

   // Entry i is the make code that selects quadrant i ('1'..'9', '0', 'A'..'F').
   localparam logic [15:0][7:0] SC_SEL = {
      8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C, 8'h45, 8'h46,
      8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16
   };

   function automatic sel_t sel_lookup(input logic [7:0] code);
      sel_t r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (code == SC_SEL[i]) begin
            r.hit = 1'b1;
            r.idx = quad_idx_t'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: 2-FF sync, falling-edge detect, 11-bit frame check, idle timeout.
// byte_vld pulses one cycle after the synchronized stop-bit edge; PS2_PARITY_CHECK_EN enables odd-parity rejection.
module ps2_rx #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] byte_dat,
   output logic       byte_vld
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1_q, clk_s2_q, clk_s3_q;
   logic          dat_s1_q, dat_s2_q;
   logic [3:0]    cnt_q, cnt_d;
   logic [9:0]    shift_q, shift_d;
   logic [TW-1:0] idle_q, idle_d;
   logic          vld_q, vld_d;
   logic [7:0]    byte_q, byte_d;
   logic          fall;
   logic          parity_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   assign fall = clk_s3_q & ~clk_s2_q;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^shift_q[9:1];
`else
   logic parity_unused;
   assign parity_unused = shift_q[9];
   assign parity_ok     = 1'b1;
`endif

   // shift_q collects start, data and parity; the stop bit is judged live on the 11th edge.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      idle_d  = idle_q;
      vld_d   = 1'b0;
      byte_d  = byte_q;
      if (fall) begin
         idle_d = '0;
         if (cnt_q == 4'd10) begin
            cnt_d  = 4'd0;
            vld_d  = ~shift_q[0] & dat_s2_q & parity_ok;
            byte_d = shift_q[8:1];
         end else begin
            shift_d = {dat_s2_q, shift_q[9:1]};
            cnt_d   = cnt_q + 4'd1;
         end
      end else if (cnt_q != 4'd0) begin
         if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
            cnt_d  = 4'd0;
            idle_d = '0;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 4'd0;
         shift_q <= '0;
         idle_q  <= '0;
         vld_q   <= 1'b0;
         byte_q  <= 8'h00;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         idle_q  <= idle_d;
         vld_q   <= vld_d;
         byte_q  <= byte_d;
      end
   end

   assign byte_dat = byte_q;
   assign byte_vld = vld_q;

endmodule

// File: rtl/ps2_quadrant_driver.sv
// Keyboard-driven 16-quadrant selector: decodes PS/2 bytes into select/confirm/clear actions.
// Outputs update one cycle after ps2_rx byte_vld; parity rejection follows PS2_PARITY_CHECK_EN.
module ps2_quadrant_driver
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] Quadrant_confirm,
   output logic [15:0] Quadrant_led,
   output logic [7:0]  Quadrant_value
);

   logic [7:0]  byte_dat;
   logic        byte_vld;
   logic        skip_q, skip_d;
   logic [15:0] led_q, led_d;
   logic [15:0] conf_q, conf_d;
   quad_idx_t   val_q, val_d;
   sel_t        sel;
   logic        have_sel;

   ps2_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .byte_dat (byte_dat),
      .byte_vld (byte_vld)
   );

   assign sel      = sel_lookup(byte_dat);
   assign have_sel = |led_q;

   always_comb begin
      skip_d = skip_q;
      led_d  = led_q;
      conf_d = conf_q;
      val_d  = val_q;
      if (byte_vld) begin
         if (skip_q) begin
            skip_d = 1'b0;
         end else if (byte_dat == SC_BREAK) begin
            skip_d = 1'b1;
         end else if (sel.hit) begin
            val_d = sel.idx;
            led_d = 16'd1 << sel.idx;
         end else if (byte_dat == SC_ENTER) begin
            if (have_sel) conf_d[val_q] = 1'b1;
         end else if (byte_dat == SC_BKSP) begin
            if (have_sel) conf_d[val_q] = 1'b0;
         end else if (byte_dat == SC_ESC) begin
            led_d  = 16'h0000;
            val_d  = '0;
            conf_d = 16'h0000;
         end
         // SC_EXT and unmapped bytes fall through with no effect.
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_q <= 1'b0;
         led_q  <= 16'h0000;
         conf_q <= 16'h0000;
         val_q  <= '0;
      end else begin
         skip_q <= skip_d;
         led_q  <= led_d;
         conf_q <= conf_d;
         val_q  <= val_d;
      end
   end

   assign Quadrant_confirm = conf_q;
   assign Quadrant_led     = led_q;
   assign Quadrant_value   = {4'b0000, val_q};

endmodule

// File: tb/tb_ps2_quadrant_driver.sv
// Randomized PS/2 frame stimulus checked every cycle against a behavioural keyboard model.
module tb_ps2_quadrant_driver;

   localparam int TO = 300;
   localparam int H  = 8;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARCHK = 1'b1;
`else
   localparam bit PARCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [15:0] Quadrant_confirm;
   logic [15:0] Quadrant_led;
   logic [7:0]  Quadrant_value;

   always #5 clk = ~clk;

   ps2_quadrant_driver #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ps2_clk          (ps2_clk),
      .ps2_data         (ps2_data),
      .Quadrant_confirm (Quadrant_confirm),
      .Quadrant_led     (Quadrant_led),
      .Quadrant_value   (Quadrant_value)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Keyboard model: selected quadrant (-1 = none), confirm set, break-skip flag.
   int          m_sel  = -1;
   logic [15:0] m_conf = 16'h0;
   bit          m_skip = 1'b0;
   bit          chk_en = 1'b0;

   logic [7:0] sel_codes [16] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                  8'h46, 8'h45, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
   logic [7:0] cmd_codes [5]  = '{8'hF0, 8'hE0, 8'h5A, 8'h66, 8'h76};

   function automatic int find_sel(input logic [7:0] b);
      int k = -1;
      for (int i = 0; i < 16; i++) if (sel_codes[i] == b) k = i;
      return k;
   endfunction

   function automatic logic [15:0] m_led();
      return (m_sel < 0) ? 16'h0 : (16'h1 << m_sel);
   endfunction

   function automatic logic [15:0] m_val();
      return (m_sel < 0) ? 16'h0 : 16'(m_sel);
   endfunction

   task automatic m_apply(input logic [7:0] b);
      int k;
      if (m_skip) m_skip = 1'b0;
      else if (b == 8'hF0) m_skip = 1'b1;
      else if (b != 8'hE0) begin
         k = find_sel(b);
         if (k >= 0) m_sel = k;
         else if (b == 8'h5A && m_sel >= 0) m_conf[m_sel] = 1'b1;
         else if (b == 8'h66 && m_sel >= 0) m_conf[m_sel] = 1'b0;
         else if (b == 8'h76) begin
            m_sel  = -1;
            m_conf = 16'h0;
         end
      end
   endtask

   task automatic m_reset();
      m_sel  = -1;
      m_conf = 16'h0;
      m_skip = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 30) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic lit(input string nm, input logic [15:0] led, input logic [15:0] val,
                      input logic [15:0] conf);
      chk({nm, ".led"}, Quadrant_led, led);
      chk({nm, ".value"}, {8'h00, Quadrant_value}, val);
      chk({nm, ".confirm"}, Quadrant_confirm, conf);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model.led", Quadrant_led, m_led());
         chk("model.value", {8'h00, Quadrant_value}, m_val());
         chk("model.confirm", Quadrant_confirm, m_conf);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send the first n bits of f LSB first; on the 11th edge, open the decode window.
   task automatic send_bits(input logic [10:0] f, input int n, input bit apply, input logic [7:0] b);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         step(H);
         ps2_clk = 1'b0;
         if (i == 10) chk_en = 1'b0;
         step(H);
         if (i == 10) begin
            if (apply) m_apply(b);
            chk_en = 1'b1;
         end
         ps2_clk = 1'b1;
      end
      step(H);
      ps2_data = 1'b1;
   endtask

   // kind: 0 good, 1 bad start, 2 bad stop, 3 bad parity
   task automatic send_byte(input logic [7:0] b, input int kind);
      logic [10:0] f;
      bit ok;
      f = {1'b1, ~^b, b, 1'b0};
      if (kind == 1) f[0] = 1'b1;
      if (kind == 2) f[10] = 1'b0;
      if (kind == 3) f[9] = ~f[9];
      ok = (kind == 0) || (kind == 3 && !PARCHK);
      send_bits(f, 11, ok, b);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      m_reset();
      step(3);
      rst_n = 1'b1;
      step(2);
   endtask

   initial begin
      logic [10:0] f;
      logic [7:0]  b;
      int          r, n;

      rst_n = 1'b0;
      m_reset();
      step(3);
      lit("reset", 16'h0000, 16'h0000, 16'h0000);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      step(5);

      send_byte(8'h16, 0);
      lit("sel0", 16'h0001, 16'h0000, 16'h0000);
      send_byte(8'h1E, 0);
      send_byte(8'h5A, 0);
      lit("confirm1", 16'h0002, 16'h0001, 16'h0002);
      send_byte(8'h26, 0);
      lit("sel2", 16'h0004, 16'h0002, 16'h0002);

      send_byte(8'hF0, 0);
      send_byte(8'h2B, 0);
      lit("break", 16'h0004, 16'h0002, 16'h0002);
      send_byte(8'h2B, 0);
      lit("selF", 16'h8000, 16'h000F, 16'h0002);

      send_byte(8'h16, 3);
      if (PARCHK) lit("parity", 16'h8000, 16'h000F, 16'h0002);
      else        lit("parity", 16'h0001, 16'h0000, 16'h0002);

      f = {1'b1, ~^8'h1E, 8'h1E, 1'b0};
      send_bits(f, 6, 1'b0, 8'h00);
      step(TO + 100);
      send_byte(8'h1E, 0);
      lit("timeout", 16'h0002, 16'h0001, 16'h0002);

      send_byte(8'h25, 0);
      send_byte(8'h5A, 0);
      send_byte(8'h5A, 0);
      lit("enter3", 16'h0008, 16'h0003, 16'h000A);
      send_byte(8'h66, 0);
      lit("bksp3", 16'h0008, 16'h0003, 16'h0002);
      send_byte(8'h5A, 0);
      send_byte(8'h76, 0);
      lit("esc", 16'h0000, 16'h0000, 16'h0000);
      send_byte(8'h5A, 0);
      lit("enter_nosel", 16'h0000, 16'h0000, 16'h0000);

      send_byte(8'hE0, 0);
      send_byte(8'h3D, 0);
      lit("ext_sel6", 16'h0040, 16'h0006, 16'h0000);

      f = {1'b1, ~^8'h45, 8'h45, 1'b0};
      send_bits(f, 4, 1'b0, 8'h00);
      reset_pulse();
      lit("rst_mid", 16'h0000, 16'h0000, 16'h0000);
      send_byte(8'h1E, 0);
      lit("after_rst", 16'h0002, 16'h0001, 16'h0000);

      for (int it = 0; it < 120; it++) begin
         r = $urandom_range(0, 99);
         if (r < 8) begin
            n = $urandom_range(1, 10);
            f = 11'($urandom);
            send_bits(f, n, 1'b0, 8'h00);
            step(TO + 50);
         end else if (r < 12) begin
            n = $urandom_range(1, 10);
            f = 11'($urandom);
            send_bits(f, n, 1'b0, 8'h00);
            reset_pulse();
         end else if (r < 22) begin
            send_byte(8'($urandom), $urandom_range(1, 3));
         end else begin
            case ($urandom_range(0, 3))
               0:       b = sel_codes[$urandom_range(0, 15)];
               1:       b = cmd_codes[$urandom_range(0, 4)];
               2:       b = cmd_codes[$urandom_range(2, 3)];
               default: b = 8'($urandom);
            endcase
            send_byte(b, 0);
         end
      end

      step(5);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
